// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch sequencer for the multicycle MIPS datapath.
// Fetches over a req/ack handshake, holds the instruction for decode, then resolves the next PC.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             Clk,
    input  logic             Rst_n,
    output logic             Imem_Req,
    output logic [31:0]      Imem_Addr,
    input  logic             Imem_Ack,
    input  logic [31:0]      Imem_Rdata,
    output logic [31:0]      Instr,
    output logic             Instr_Valid,
    input  logic             Exec_Done,
    input  logic             Branch_Taken,
    input  logic [31:0]      Branch_Offset_Shifted,
    input  logic             Jump,
    input  logic [25:0]      Jump_Index,
    output logic [31:0]      PC,
    output logic [31:0]      PC_Plus4,
    output logic [CNT_W-1:0] Instr_Count,
    output logic             Align_Err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] next_pc;
    logic        fetch_hit;
    logic        retire;
    logic        misalign;

    // Jump keeps the upper nibble of the sequential PC; branch offsets ignore their low bits.
    function automatic logic [31:0] calc_next_pc(
        input logic [31:0] pc4,
        input logic        jmp,
        input logic        taken,
        input logic [31:0] offset,
        input logic [25:0] index
    );
        logic [31:0] result;
        if (jmp)
            result = {pc4[31:28], index, 2'b00};
        else if (taken)
            result = pc4 + {offset[31:2], 2'b00};
        else
            result = pc4;
        return result;
    endfunction

    assign PC_Plus4    = PC + 32'd4;
    assign Imem_Addr   = PC;
    assign Imem_Req    = (state == FETCH);
    assign Instr_Valid = (state == EXEC);

    assign fetch_hit = (state == FETCH) && Imem_Ack;
    assign retire    = (state == EXEC) && Exec_Done;
    assign misalign  = retire && Branch_Taken && !Jump && (Branch_Offset_Shifted[1:0] != 2'b00);
    assign next_pc   = calc_next_pc(PC_Plus4, Jump, Branch_Taken, Branch_Offset_Shifted, Jump_Index);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = FETCH;
            FETCH:   if (Imem_Ack) state_nxt = EXEC;
            EXEC:    if (Exec_Done) state_nxt = FETCH;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state       <= IDLE;
            PC          <= RESET_PC;
            Instr       <= 32'd0;
            Instr_Count <= '0;
            Align_Err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (fetch_hit)
                Instr <= Imem_Rdata;
            if (retire) begin
                PC          <= next_pc;
                Instr_Count <= Instr_Count + CNT_W'(1);
            end
            if (misalign)
                Align_Err <= 1'b1;
        end
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Program-counter and instruction-fetch sequencer for the multicycle MIPS datapath. It consumes the word-aligned branch offset from the shift-left-2 stage, the jump index and branch/jump decisions, and computes the next PC. It drives a req/ack instruction-memory handshake and presents the fetched instruction to decode until the datapath signals completion.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
CNT_W, 32, width of the retired-instruction counter.

Ports:
Clk  input  1  rising-edge clock
Rst_n  input  1  asynchronous active-low reset
Imem_Req  output  1  fetch request to instruction memory
Imem_Addr  output  32  fetch address; equals PC
Imem_Ack  input  1  memory has valid Imem_Rdata this cycle
Imem_Rdata  input  32  instruction word from memory
Instr  output  32  captured instruction, held for decode
Instr_Valid  output  1  Instr is valid and the instruction is executing
Exec_Done  input  1  datapath finished current instruction; resolve next PC
Branch_Taken  input  1  conditional branch taken (sampled with Exec_Done)
Branch_Offset_Shifted  input  32  sign-extended immediate already shifted left 2
Jump  input  1  J-type jump (sampled with Exec_Done)
Jump_Index  input  26  instruction bits [25:0]
PC  output  32  current PC
PC_Plus4  output  32  PC + 4, combinational, modulo 2^32
Instr_Count  output  CNT_W  retired-instruction count
Align_Err  output  1  sticky: offset input had nonzero bits [1:0]

Behaviour:
- Clock and reset: single clock Clk. Rst_n is asynchronous and active-low.
- Reset values: state=IDLE, PC=RESET_PC, Instr=0, Instr_Valid=0, Imem_Req=0, Instr_Count=0, Align_Err=0.
- States: IDLE, FETCH, EXEC.
- IDLE: Imem_Req=0. Moves to FETCH on the first clock edge after Rst_n deasserts.
- FETCH: Imem_Req=1 and Imem_Addr=PC; both held stable until Ack.
  - When Imem_Ack=1 at a rising edge: Instr<=Imem_Rdata, Instr_Valid<=1, go to EXEC.
  - Ack may arrive in the same cycle Req first rises, giving 1-cycle fetch latency.
- EXEC: Imem_Req=0 and Instr_Valid=1; Instr is held.
  - Exec_Done=0: stay in EXEC (stall, unbounded).
  - Exec_Done=1 at an edge: PC<=next_pc, Instr_Valid<=0, Instr_Count<=Instr_Count+1 (wraps to 0 at all-ones), go to FETCH.
- next_pc priority:
  - Jump=1 (wins over Branch_Taken): {PC_Plus4[31:28], Jump_Index, 2'b00}.
  - else Branch_Taken=1: PC_Plus4 + {Branch_Offset_Shifted[31:2], 2'b00}, modulo 2^32.
  - else: PC_Plus4.
- Alignment: if Branch_Taken=1, Jump=0, Exec_Done=1 and Branch_Offset_Shifted[1:0]!=0, set Align_Err<=1. The target is still computed with the low bits forced to 0. Align_Err clears only on reset.
- Ignored inputs:
  - Imem_Ack outside FETCH.
  - Exec_Done, Branch_Taken and Jump outside EXEC.
  - Branch_Offset_Shifted when Branch_Taken=0 or Jump=1 (no Align_Err).
- Wrap-around: PC=32'hFFFF_FFFC with a sequential next PC gives 32'h0000_0000. Negative offsets wrap modulo 2^32.
- Reset mid-operation: asserting Rst_n in any state immediately forces all reset values, dropping Imem_Req combinationally. A late Ack after reset release is ignored unless the block is in FETCH.
- Imem_Req is decoded from registered state only, with no combinational path from any input.

Test Plan:
- Reset/boot: hold Rst_n=0 for 3 cycles, then release -> Imem_Req=0 while in reset; Imem_Req=1 with Imem_Addr=32'h0 one edge after release.
- Sequential fetch: Ack same cycle with Rdata=32'h2008_0005, then Exec_Done after 2 cycles -> Instr held for 2 cycles, Instr_Valid=1, PC becomes 32'h4, Instr_Count=1.
- Branch: PC=32'h100, Branch_Taken=1, Branch_Offset_Shifted=32'hFFFF_FFF0 -> PC=32'h0F4. Same stimulus with offset 32'h40 -> PC=32'h144.
- Jump vs branch: PC=32'h1000_0000, Jump=1 and Branch_Taken=1, Jump_Index=26'h00_0040 -> PC=32'h1000_0100.
- Wrap and stall: PC=32'hFFFF_FFFC, Ack delayed 4 cycles -> Req and Addr stable for all 4 cycles. Then Exec_Done with no branch -> PC=32'h0.
- Misalign and mid-reset: Branch_Taken with offset 32'h0000_0011 -> Align_Err=1 and target uses offset 32'h10. Then pull Rst_n low while in FETCH -> Req drops immediately, Align_Err=0, PC=RESET_PC.
